reg_32_checker: RTL and testbench
=================================

// Module: reg_32_checker
// PURPOSE
// - Response checker for the 32-bit shift register (reg_32).
// - Snoops the stimulus the tester drives (ENB, DIR, S_IN, MODO, D) and the DUT response (Q, S_OUT).
// - Runs a golden model of the register, compares it every cycle, and counts and records mismatches.
// - Sits beside the DUT in every reg_32 bench; the stimulus tester and the DUT are unchanged.
// PARAMETERS
// - CNT_W        default 16   width of the check and error counters; both saturate at all-ones.
// - STOP_ON_ERR  default 0    1: the first mismatch freezes checking (FAIL state).
// PORTS
// - CLK        in   1   single clock; the DUT and the model update on posedge.
// - RST        in   1   asynchronous, active-high reset.
// - ENB        in   1   DUT enable as driven by the tester (1 = enabled).
// - DIR        in   1   0 = shift/rotate left (toward MSB), 1 = right.
// - S_IN       in   1   serial input bit.
// - MODO       in   2   00 shift, 01 rotate, 10 parallel load, 11 hold.
// - D          in   32  parallel load data.
// - Q          in   32  DUT register output.
// - S_OUT      in   8   DUT per-nibble serial outputs.
// - SYNCED     out  1   model holds a known value; checking is active.
// - ERR        out  1   one-cycle pulse on a mismatch.
// - FAIL       out  1   sticky; set on the first mismatch.
// - CHK_CNT    out  CNT_W  number of compares performed.
// - ERR_CNT    out  CNT_W  number of mismatching compares.
// - EXP_Q      out  32  expected Q captured at the first mismatch.
// - GOT_Q      out  32  actual Q captured at the first mismatch.
// BEHAVIOUR
// - Reset (async, RST=1): all outputs go to 0, the model goes to 0 and the FSM goes to IDLE. Reset mid-run discards all history.
// - Model update, posedge CLK with ENB=1 (ENB=0 holds the model):
//   - MODO=10: M <= D.
//   - MODO=00, DIR=0: M <= {M[30:0],S_IN}.
//   - MODO=00, DIR=1: M <= {S_IN,M[31:1]}.
//   - MODO=01, DIR=0: M <= {M[30:0],M[31]}.
//   - MODO=01, DIR=1: M <= {M[0],M[31:1]}.
//   - MODO=11: hold.
// - Expected S_OUT[k], for k=0..7, is combinational from M and the current DIR: DIR=0 gives M[4k+3]; DIR=1 gives M[4k].
// - FSM IDLE -> SYNC: on the first enabled posedge with MODO=10. Before this the model is unknown and nothing is compared.
// - FSM SYNC -> CHECK: on the next posedge. SYNCED=1 from CHECK onward.
// - CHECK, each posedge:
//   - Compare Q against M and S_OUT against the expected S_OUT; both are values held since the previous edge, so compare latency is 1 cycle after the stimulus edge.
//   - CHK_CNT is incremented on every compare.
//   - On a mismatch: ERR=1 for that cycle and ERR_CNT is incremented.
//   - On the first mismatch only: FAIL is set, and EXP_Q and GOT_Q are captured.
// - CHECK -> FAIL state: only when STOP_ON_ERR=1. In this state counters and the model freeze; only RST leaves it.
// - With STOP_ON_ERR=0 the FSM stays in CHECK and the FAIL output stays sticky.
// - Counters saturate and never wrap.
// - A load during CHECK re-seeds M and is not an error.
// - ENB=0 cycles are still compared (the DUT must hold) and are counted.
// - MODO=11 with ENB=1: both the DUT and the model hold; compare as normal.
// TESTING
// - Reset, then no load for 10 clocks -> SYNCED=0, CHK_CNT=0, ERR=0.
// - Load D=32'h00000001, then 32 rotate-left clocks with a correct DUT -> ERR_CNT=0; Q back to 32'h00000001; CHK_CNT=32.
// - Load 32'h80000000, shift right with S_IN=1 for 4 clocks -> expected Q=32'hF8000000 and S_OUT=8'h80 (DIR=1); no error.
// - Force DUT Q bit 5 wrong on compare 3 -> ERR pulses once, ERR_CNT=1, FAIL=1, EXP_Q/GOT_Q differ only in bit 5.
// - STOP_ON_ERR=1 with persistent corruption -> ERR_CNT stays 1 and CHK_CNT freezes.
// - RST asserted mid-CHECK -> all outputs 0 immediately; next load re-syncs.

Source files
------------

// File: rtl/reg_32_checker.sv
// Response checker for the 32-bit shift register: runs a golden model of reg_32
// beside the DUT, compares Q and S_OUT every cycle, and counts/records mismatches.
module reg_32_checker #(
  parameter int unsigned CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             DIR,
  input  logic             S_IN,
  input  logic [1:0]       MODO,
  input  logic [31:0]      D,
  input  logic [31:0]      Q,
  input  logic [7:0]       S_OUT,
  output logic             SYNCED,
  output logic             ERR,
  output logic             FAIL,
  output logic [CNT_W-1:0] CHK_CNT,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [31:0]      EXP_Q,
  output logic [31:0]      GOT_Q
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NIB_N  = 8;

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SYNC  = 2'b01,
    ST_CHECK = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   model;
  logic [DATA_W-1:0]   model_next_c;
  logic [NIB_N-1:0]    exp_sout_c;
  logic                mismatch_c;

  // Golden register next value; a disabled cycle holds.
  always_comb begin
    model_next_c = model;
    if (ENB) begin
      unique case (MODO)
        MODE_LOAD:  model_next_c = D;
        MODE_SHIFT: model_next_c = DIR ? {S_IN, model[DATA_W-1:1]}
                                       : {model[DATA_W-2:0], S_IN};
        MODE_ROT:   model_next_c = DIR ? {model[0], model[DATA_W-1:1]}
                                       : {model[DATA_W-2:0], model[DATA_W-1]};
        default:    model_next_c = model;
      endcase
    end
  end

  // Each nibble's serial output is its leading bit in the current shift direction.
  always_comb begin
    exp_sout_c = '0;
    for (int k = 0; k < int'(NIB_N); k++) begin
      exp_sout_c[k] = DIR ? model[4*k] : model[4*k+3];
    end
  end

  assign mismatch_c = (Q != model) || (S_OUT != exp_sout_c);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      model   <= '0;
      SYNCED  <= 1'b0;
      ERR     <= 1'b0;
      FAIL    <= 1'b0;
      CHK_CNT <= '0;
      ERR_CNT <= '0;
      EXP_Q   <= '0;
      GOT_Q   <= '0;
    end else begin
      ERR <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          model <= model_next_c;
          if (ENB && (MODO == MODE_LOAD)) begin
            state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          model  <= model_next_c;
          state  <= ST_CHECK;
          SYNCED <= 1'b1;
        end
        ST_CHECK: begin
          // Q and M compared here both reflect the previous edge.
          model <= model_next_c;
          if (CHK_CNT != CNT_MAX) begin
            CHK_CNT <= CHK_CNT + CNT_ONE;
          end
          if (mismatch_c) begin
            ERR <= 1'b1;
            if (ERR_CNT != CNT_MAX) begin
              ERR_CNT <= ERR_CNT + CNT_ONE;
            end
            if (!FAIL) begin
              FAIL  <= 1'b1;
              EXP_Q <= model;
              GOT_Q <= Q;
            end
            if (STOP_ON_ERR) begin
              state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_32_checker.sv
// Scoreboard bench for reg_32_checker: a stand-in reg_32 drives Q/S_OUT (with
// injectable corruption) and a spec-level model predicts each checker's outputs.
module tb_reg_32_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enb = 1'b0;
  logic        dir = 1'b0;
  logic        s_in = 1'b0;
  logic [1:0]  modo = 2'b11;
  logic [31:0] d = '0;
  logic [31:0] q = '0;
  logic [7:0]  s_out = '0;

  logic        syn [3];
  logic        errp [3];
  logic        fl [3];
  logic [31:0] eq [3];
  logic [31:0] gq [3];
  logic [15:0] chk0, chk1, errc0, errc1;
  logic [3:0]  chk2, errc2;

  reg_32_checker #(.CNT_W(16), .STOP_ON_ERR(1'b0)) u_free (
    .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo), .D(d),
    .Q(q), .S_OUT(s_out), .SYNCED(syn[0]), .ERR(errp[0]), .FAIL(fl[0]),
    .CHK_CNT(chk0), .ERR_CNT(errc0), .EXP_Q(eq[0]), .GOT_Q(gq[0]));

  reg_32_checker #(.CNT_W(16), .STOP_ON_ERR(1'b1)) u_stop (
    .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo), .D(d),
    .Q(q), .S_OUT(s_out), .SYNCED(syn[1]), .ERR(errp[1]), .FAIL(fl[1]),
    .CHK_CNT(chk1), .ERR_CNT(errc1), .EXP_Q(eq[1]), .GOT_Q(gq[1]));

  reg_32_checker #(.CNT_W(4), .STOP_ON_ERR(1'b0)) u_small (
    .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .S_IN(s_in), .MODO(modo), .D(d),
    .Q(q), .S_OUT(s_out), .SYNCED(syn[2]), .ERR(errp[2]), .FAIL(fl[2]),
    .CHK_CNT(chk2), .ERR_CNT(errc2), .EXP_Q(eq[2]), .GOT_Q(gq[2]));

  typedef struct {
    bit          syn;
    bit          err;
    bit          fl;
    int          chk;
    int          errc;
    logic [31:0] eq;
    logic [31:0] gq;
  } obs_t;

  // phase: 0 = model unknown, 1 = just loaded, 2 = comparing
  typedef struct {
    int          phase;
    bit          halted;
    logic [31:0] m;
    obs_t        o;
  } cm_t;

  int   cmax  [3] = '{65535, 65535, 15};
  bit   stopv [3] = '{1'b0, 1'b1, 1'b0};
  cm_t  st    [3];
  obs_t sb    [3][$];

  logic [31:0] q_true = '0;
  bit          rst_prev = 1'b1;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic obs_t zero_obs();
    obs_t o;
    o.syn = 1'b0; o.err = 1'b0; o.fl = 1'b0;
    o.chk = 0; o.errc = 0; o.eq = '0; o.gq = '0;
    return o;
  endfunction

  function automatic cm_t cm_zero();
    cm_t s;
    s.phase = 0; s.halted = 1'b0; s.m = '0; s.o = zero_obs();
    return s;
  endfunction

  function automatic logic [31:0] reg_next(logic [31:0] m, bit e, bit dr, bit si,
                                           logic [1:0] mo, logic [31:0] dd);
    logic [31:0] sin_w;
    sin_w = {31'b0, si};
    if (!e) return m;
    case (mo)
      2'b10:   return dd;
      2'b00:   return dr ? ((m >> 1) | (sin_w << 31)) : ((m << 1) | sin_w);
      2'b01:   return dr ? ((m >> 1) | (m << 31)) : ((m << 1) | (m >> 31));
      default: return m;
    endcase
  endfunction

  function automatic logic [7:0] sout_of(logic [31:0] m, bit dr);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = dr ? m[4*k] : m[4*k+3];
    return r;
  endfunction

  function automatic int sat_inc(int v, int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  // Checker behaviour at one clock edge, from the pre-edge inputs.
  function automatic cm_t cm_step(cm_t s, int mx, bit stop, bit r, bit e, bit dr, bit si,
                                  logic [1:0] mo, logic [31:0] dd, logic [31:0] qq,
                                  logic [7:0] so);
    cm_t n;
    bit  bad;
    if (r) return cm_zero();
    n = s;
    n.o.err = 1'b0;
    if (s.halted) return n;
    if (s.phase == 2) begin
      bad = (qq !== s.m) || (so !== sout_of(s.m, dr));
      n.o.chk = sat_inc(s.o.chk, mx);
      if (bad) begin
        n.o.err  = 1'b1;
        n.o.errc = sat_inc(s.o.errc, mx);
        if (!s.o.fl) begin
          n.o.fl = 1'b1;
          n.o.eq = s.m;
          n.o.gq = qq;
        end
        if (stop) n.halted = 1'b1;
      end
    end
    n.m = reg_next(s.m, e, dr, si, mo, dd);
    if (s.phase == 0 && e && mo == 2'b10) n.phase = 1;
    else if (s.phase == 1) n.phase = 2;
    n.o.syn = (n.phase == 2);
    return n;
  endfunction

  function automatic obs_t get_obs(int i);
    obs_t o;
    o.syn = syn[i]; o.err = errp[i]; o.fl = fl[i]; o.eq = eq[i]; o.gq = gq[i];
    case (i)
      0:       begin o.chk = int'(32'(chk0)); o.errc = int'(32'(errc0)); end
      1:       begin o.chk = int'(32'(chk1)); o.errc = int'(32'(errc1)); end
      default: begin o.chk = int'(32'(chk2)); o.errc = int'(32'(errc2)); end
    endcase
    return o;
  endfunction

  task automatic check(int i, obs_t g, obs_t w, string tag);
    n_cmp++;
    if (g.syn !== w.syn || g.err !== w.err || g.fl !== w.fl || g.chk != w.chk ||
        g.errc != w.errc || g.eq !== w.eq || g.gq !== w.gq) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc%0d: got syn=%b err=%b fail=%b chk=%0d errc=%0d exp_q=%h got_q=%h | want syn=%b err=%b fail=%b chk=%0d errc=%0d exp_q=%h got_q=%h",
               tag, i, cyc, g.syn, g.err, g.fl, g.chk, g.errc, g.eq, g.gq,
               w.syn, w.err, w.fl, w.chk, w.errc, w.eq, w.gq);
    end
  endtask

  task automatic expect_val(string tag, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc%0d: got %h want %h", tag, cyc, got, want);
    end
  endtask

  // One tester cycle: drive at negedge, predict outputs for the coming posedge.
  task automatic step(bit r, bit e, bit dr, bit si, logic [1:0] mo, logic [31:0] dd,
                      logic [31:0] qerr, logic [7:0] serr);
    @(negedge clk);
    rst = r; enb = e; dir = dr; s_in = si; modo = mo; d = dd;
    q = q_true ^ qerr;
    s_out = sout_of(q_true, dr) ^ serr;
    if (r && !rst_prev) begin
      #1;
      for (int i = 0; i < 3; i++) check(i, get_obs(i), zero_obs(), "async_rst");
    end
    rst_prev = r;
    for (int i = 0; i < 3; i++) begin
      st[i] = cm_step(st[i], cmax[i], stopv[i], r, e, dr, si, mo, dd, q, s_out);
      sb[i].push_back(st[i].o);
    end
    q_true = r ? 32'h0 : reg_next(q_true, e, dr, si, mo, dd);
    cyc++;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [1:0] rand_nonload();
    case ($urandom % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Monitor: pop and compare once per edge, independent of the stimulus.
  initial begin
    obs_t w;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sb[i].size() > 0) begin
          w = sb[i].pop_front();
          check(i, get_obs(i), w, "scoreboard");
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  mo;
    logic [31:0] qe;
    logic [7:0]  se;
    for (int i = 0; i < 3; i++) st[i] = cm_zero();

    step(1, 0, 0, 0, 2'b11, 0, 0, 0);
    step(1, 0, 0, 0, 2'b11, 0, 0, 0);

    // No load yet: mismatches must be ignored.
    for (int n = 0; n < 10; n++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), rand_nonload(), $urandom, $urandom, 8'($urandom));
    settle();
    expect_val("idle_synced", 32'(syn[0]), 32'h0);
    expect_val("idle_chk", 32'(chk0), 32'h0);

    // Load 1 and rotate left 32 times, one extra edge to compare the last result.
    step(0, 1, 0, 0, 2'b10, 32'h00000001, 0, 0);
    for (int n = 0; n < 32; n++) step(0, 1, 0, 0, 2'b01, $urandom, 0, 0);
    step(0, 1, 0, 0, 2'b11, $urandom, 0, 0);
    settle();
    expect_val("rot_chk", 32'(chk0), 32'd32);
    expect_val("rot_errc", 32'(errc0), 32'd0);
    expect_val("rot_q", q_true, 32'h00000001);

    // Shift right with S_IN=1 from the MSB.
    step(0, 1, 1, 0, 2'b10, 32'h80000000, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 1, 1, 1, 2'b00, $urandom, 0, 0);
    expect_val("shr_q", q_true, 32'hF8000000);
    expect_val("shr_sout", 32'(sout_of(q_true, 1'b1)), 32'h80);
    step(0, 1, 1, 0, 2'b11, $urandom, 0, 0);
    settle();
    expect_val("shr_errc", 32'(errc0), 32'd0);

    // Single bit-5 corruption.
    step(0, 1, 0, 0, 2'b10, 32'h12345678, 0, 0);
    step(0, 1, 0, 0, 2'b01, 0, 0, 0);
    step(0, 0, 0, 0, 2'b01, 0, 32'h00000020, 0);
    step(0, 1, 1, 0, 2'b01, 0, 0, 0);
    step(0, 1, 1, 0, 2'b11, 0, 0, 0);
    settle();
    expect_val("bit5_errc", 32'(errc0), 32'd1);
    expect_val("bit5_fail", 32'(fl[0]), 32'd1);
    expect_val("bit5_diff", eq[0] ^ gq[0], 32'h00000020);

    // Persistent corruption: the stopping checker stays frozen.
    for (int n = 0; n < 6; n++) step(0, 1, 0, 1'($urandom), 2'b00, 0, 32'h000000FF, 0);
    step(0, 1, 0, 0, 2'b11, 0, 0, 8'h01);
    settle();
    expect_val("stop_errc", 32'(errc1), 32'd1);

    // Reset mid-check, then re-sync.
    step(1, 1, 0, 0, 2'b01, 0, 0, 0);
    step(1, 0, 0, 0, 2'b11, 0, 0, 0);
    for (int n = 0; n < 3; n++) step(0, 1, 0, 0, 2'b00, 0, $urandom, 0);
    step(0, 1, 0, 0, 2'b10, $urandom, 0, 0);
    for (int n = 0; n < 10; n++)
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), rand_nonload(), $urandom, 0, 0);

    // Random traffic with occasional loads and sparse corruption.
    for (int n = 0; n < 400; n++) begin
      mo = (($urandom % 10) == 0) ? 2'b10 : rand_nonload();
      qe = (($urandom % 20) == 0) ? (32'h1 << ($urandom % 32)) : 32'h0;
      se = (($urandom % 30) == 0) ? (8'h1 << ($urandom % 8)) : 8'h0;
      step(0, ($urandom % 8) != 0, 1'($urandom), 1'($urandom), mo, $urandom, qe, se);
    end

    step(0, 0, 0, 0, 2'b11, 0, 0, 0);
    step(0, 0, 0, 0, 2'b11, 0, 0, 0);
    repeat (3) settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
